// File: rtl/transconv_layer_sequencer_pkg.sv
// transconv_layer_sequencer_pkg: shared state encoding, error codes and header instruction codes
package transconv_layer_sequencer_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        LOAD_X  = 3'd2,
        COMPUTE = 3'd3,
        READ_Y  = 3'd4,
        DONE    = 3'd5,
        ERR     = 3'd6
    } state_e;
    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_BAD_INSTR  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT    = 2'd2;
    localparam logic [1:0] ERR_UNEXP_DONE = 2'd3;
    localparam logic [7:0] INSTR_WR_W = 8'h01;
    localparam logic [7:0] INSTR_WR_X = 8'h02;
    localparam logic [7:0] INSTR_RD_Y = 8'h03;
    function automatic logic [7:0] expected_instr(input state_e s);
        return s == LOAD_W ? INSTR_WR_W : s == LOAD_X ? INSTR_WR_X : INSTR_RD_Y;
    endfunction
endpackage

// File: rtl/transconv_layer_sequencer_phase_watchdog.sv
// phase_watchdog: per-phase cycle counter, cleared on phase entry, expiring when the
// cycle being counted brings the total to a nonzero limit
module phase_watchdog #(
    parameter int W = 24
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         clr,
    input  logic         run,
    input  logic [W-1:0] limit,
    output logic         expired
);
    logic [W-1:0] cnt;
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (run)
            cnt <= cnt + W'(1);
    end
    assign expired = run && limit != '0 && cnt + W'(1) == limit;
endmodule

// File: rtl/transconv_layer_sequencer.sv
// transconv_layer_sequencer: walks a layer through weight load, per-tile input load,
// compute and readback, checking DMA headers and guarding each phase with a watchdog
module transconv_layer_sequencer
    import transconv_layer_sequencer_pkg::*;
#(
    parameter int TILE_W    = 8,
    parameter int TIMEOUT_W = 24
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [TILE_W-1:0]    cfg_num_tiles,
    input  logic [TIMEOUT_W-1:0] cfg_timeout,
    input  logic                 header_valid,
    input  logic [7:0]           instr_code,
    input  logic                 write_done,
    input  logic                 read_done,
    input  logic                 comp_done,
    output logic                 comp_start,
    output logic                 bram_owner,
    output logic                 dma_allow,
    output logic                 busy,
    output logic                 layer_done,
    output logic                 error,
    output logic [1:0]           err_code,
    output logic [TILE_W-1:0]    tile_idx,
    output logic [2:0]           state_dbg
);
    state_e                state, nxt;
    logic [TILE_W-1:0]     tiles, tile_nxt;
    logic [TIMEOUT_W-1:0]  timeout;
    logic [1:0]            err_nxt, fault;
    logic                  active, adv, last, expired;

    assign active = state inside {LOAD_W, LOAD_X, COMPUTE, READ_Y};
    assign last   = tile_idx == tiles - TILE_W'(1);
    assign adv    = state == COMPUTE ? comp_done : state == READ_Y ? read_done : write_done;
    // The expected done pulse is tested before any fault, so it wins a same-cycle expiry
    assign fault  = header_valid && state != COMPUTE && instr_code != expected_instr(state) ? ERR_BAD_INSTR
                  : state == COMPUTE && (write_done || read_done) ? ERR_UNEXP_DONE
                  : expired ? ERR_TIMEOUT : ERR_NONE;

    always_comb begin
        nxt      = state;
        err_nxt  = err_code;
        tile_nxt = tile_idx;
        if (abort) begin
            nxt      = IDLE;
            err_nxt  = ERR_NONE;
            tile_nxt = '0;
        end else if (state == IDLE) begin
            if (start) begin
                nxt      = LOAD_W;
                tile_nxt = '0;
            end
        end else if (state == DONE) begin
            nxt = IDLE;
        end else if (active && adv) begin
            nxt      = state == LOAD_W ? LOAD_X : state == LOAD_X ? COMPUTE
                     : state == COMPUTE ? READ_Y : last ? DONE : LOAD_X;
            tile_nxt = state == READ_Y && !last ? tile_idx + TILE_W'(1) : tile_idx;
        end else if (active && fault != ERR_NONE) begin
            nxt     = ERR;
            err_nxt = fault;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state      <= IDLE;
            tiles      <= '0;
            timeout    <= '0;
            tile_idx   <= '0;
            err_code   <= ERR_NONE;
            comp_start <= 1'b0;
            bram_owner <= 1'b0;
            dma_allow  <= 1'b0;
            busy       <= 1'b0;
            layer_done <= 1'b0;
            error      <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && start && !abort) begin
                tiles   <= cfg_num_tiles == '0 ? TILE_W'(1) : cfg_num_tiles;
                timeout <= cfg_timeout;
            end
            tile_idx   <= tile_nxt;
            err_code   <= err_nxt;
            comp_start <= nxt == COMPUTE && state != COMPUTE;
            bram_owner <= nxt == COMPUTE;
            dma_allow  <= nxt inside {LOAD_W, LOAD_X, READ_Y};
            busy       <= nxt != IDLE;
            layer_done <= nxt == DONE;
            error      <= nxt == ERR;
        end
    end

    assign state_dbg = state;

    phase_watchdog #(.W(TIMEOUT_W)) u_watchdog (
        .aclk    (aclk),
        .areset  (areset),
        .clr     (nxt != state),
        .run     (active),
        .limit   (timeout),
        .expired (expired)
    );
endmodule

// File: tb/tb_transconv_layer_sequencer.sv
// tb_transconv_layer_sequencer: directed layer scenarios checked every cycle against a
// phase-level behavioural model, plus hand-computed checkpoints
module tb_transconv_layer_sequencer;
    localparam int TILE_W = 8;
    localparam int TIMEOUT_W = 24;
    localparam int IDLE = 0, LOAD_W = 1, LOAD_X = 2, COMPUTE = 3, READ_Y = 4, DONE = 5, ERR = 6;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    logic start = 1'b0, abort = 1'b0, header_valid = 1'b0;
    logic write_done = 1'b0, read_done = 1'b0, comp_done = 1'b0;
    logic [TILE_W-1:0] cfg_num_tiles = '0;
    logic [TIMEOUT_W-1:0] cfg_timeout = '0;
    logic [7:0] instr_code = '0;
    logic comp_start, bram_owner, dma_allow, busy, layer_done, error;
    logic [1:0] err_code;
    logic [TILE_W-1:0] tile_idx;
    logic [2:0] state_dbg;

    int n_cmp = 0, n_fail = 0;
    int m_st = 0, m_tile = 0, m_tiles = 0, m_to = 0, m_cnt = 0, m_err = 0;
    bit m_cs = 0;
    int cs_cnt = 0, ld_cnt = 0;

    transconv_layer_sequencer #(.TILE_W(TILE_W), .TIMEOUT_W(TIMEOUT_W)) dut (
        .aclk(aclk), .areset(areset), .start(start), .abort(abort),
        .cfg_num_tiles(cfg_num_tiles), .cfg_timeout(cfg_timeout),
        .header_valid(header_valid), .instr_code(instr_code),
        .write_done(write_done), .read_done(read_done), .comp_done(comp_done),
        .comp_start(comp_start), .bram_owner(bram_owner), .dma_allow(dma_allow),
        .busy(busy), .layer_done(layer_done), .error(error), .err_code(err_code),
        .tile_idx(tile_idx), .state_dbg(state_dbg)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_st = IDLE; m_tile = 0; m_tiles = 0; m_to = 0; m_cnt = 0; m_err = 0; m_cs = 0;
    endfunction

    // One clock of the layer protocol, evaluated from the inputs present at the edge
    function automatic void model_step();
        int nst = m_st;
        int exp_code = m_st == LOAD_W ? 1 : m_st == LOAD_X ? 2 : 3;
        bit done = m_st == COMPUTE ? comp_done : m_st == READ_Y ? read_done : write_done;
        if (areset) begin
            model_reset();
            return;
        end
        if (abort) begin
            nst = IDLE; m_tile = 0; m_err = 0;
        end else if (m_st == IDLE) begin
            if (start) begin
                m_tiles = cfg_num_tiles == 0 ? 1 : int'(cfg_num_tiles);
                m_to = int'(cfg_timeout);
                m_tile = 0;
                nst = LOAD_W;
            end
        end else if (m_st == DONE) begin
            nst = IDLE;
        end else if (m_st != ERR) begin
            if (done) begin
                if (m_st != READ_Y) nst = m_st + 1;
                else if (m_tile + 1 == m_tiles) nst = DONE;
                else begin m_tile++; nst = LOAD_X; end
            end else if (header_valid && m_st != COMPUTE && instr_code != exp_code) begin
                nst = ERR; m_err = 1;
            end else if (m_st == COMPUTE && (write_done || read_done)) begin
                nst = ERR; m_err = 3;
            end else if (m_to != 0 && m_cnt + 1 >= m_to) begin
                nst = ERR; m_err = 2;
            end
        end
        m_cs = nst == COMPUTE && m_st != COMPUTE;
        m_cnt = nst == m_st ? m_cnt + 1 : 0;
        m_st = nst;
    endfunction

    always @(negedge aclk) begin
        chk("state_dbg", state_dbg, m_st);
        chk("busy", busy, m_st != IDLE);
        chk("bram_owner", bram_owner, m_st == COMPUTE);
        chk("dma_allow", dma_allow, m_st == LOAD_W || m_st == LOAD_X || m_st == READ_Y);
        chk("layer_done", layer_done, m_st == DONE);
        chk("error", error, m_st == ERR);
        chk("err_code", err_code, m_err);
        chk("tile_idx", tile_idx, m_tile);
        chk("comp_start", comp_start, m_cs);
        if (comp_start) cs_cnt++;
        if (layer_done) ld_cnt++;
    end

    task automatic tick();
        @(posedge aclk);
        model_step();
        #1;
        {start, abort, header_valid, write_done, read_done, comp_done} = '0;
    endtask

    task automatic go(input int tiles, input int to);
        cfg_num_tiles = TILE_W'(tiles); cfg_timeout = TIMEOUT_W'(to); start = 1'b1; tick();
    endtask
    task automatic hdr(input logic [7:0] c); header_valid = 1'b1; instr_code = c; tick(); endtask
    task automatic wdone(); write_done = 1'b1; tick(); endtask
    task automatic rdone(); read_done = 1'b1; tick(); endtask
    task automatic cdone(); comp_done = 1'b1; tick(); endtask
    task automatic do_abort(); abort = 1'b1; tick(); endtask

    initial begin
        int k;
        tick(); tick();
        chk("rst_state", state_dbg, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_code", err_code, 0);
        areset = 1'b0;
        tick();

        // two-tile layer, watchdog disabled
        cs_cnt = 0; ld_cnt = 0;
        go(2, 0);
        chk("run_load_w", state_dbg, LOAD_W);
        hdr(8'h01); wdone(); hdr(8'h02); wdone();
        chk("run_comp_start", comp_start, 1);
        chk("run_owner", bram_owner, 1);
        tick(); cdone(); hdr(8'h03);
        chk("run_tile0", tile_idx, 0);
        rdone();
        chk("run_tile1", tile_idx, 1);
        chk("run_back_to_x", state_dbg, LOAD_X);
        hdr(8'h02); wdone(); cdone(); hdr(8'h03); rdone();
        chk("run_layer_done", layer_done, 1);
        tick();
        chk("run_idle", state_dbg, IDLE);
        chk("run_comp_starts", cs_cnt, 2);
        chk("run_layer_dones", ld_cnt, 1);

        // wrong header in LOAD_W, held until abort; start is ignored in ERR
        go(1, 0); hdr(8'h03);
        chk("bad_state", state_dbg, ERR);
        chk("bad_code", err_code, 1);
        chk("bad_dma", dma_allow, 0);
        start = 1'b1; tick(); tick(); tick();
        chk("bad_hold", err_code, 1);
        do_abort();
        chk("bad_abort_state", state_dbg, IDLE);
        chk("bad_abort_code", err_code, 0);

        // write_done during COMPUTE
        go(1, 0); wdone(); wdone(); wdone();
        chk("unexp_code", err_code, 3);
        do_abort();

        // watchdog expiry in COMPUTE
        go(1, 100); wdone(); wdone();
        chk("to_in_compute", state_dbg, COMPUTE);
        k = 0;
        while (state_dbg != 3'(ERR) && k < 300) begin tick(); k++; end
        chk("to_cycles", k, 100);
        chk("to_code", err_code, 2);
        do_abort();

        // read_done on the exact expiry cycle of READ_Y
        go(2, 3); wdone(); wdone(); cdone(); tick(); tick(); rdone();
        chk("race_error", error, 0);
        chk("race_state", state_dbg, LOAD_X);
        chk("race_tile", tile_idx, 1);
        do_abort();

        // zero tiles behaves as one tile
        cs_cnt = 0; ld_cnt = 0;
        go(0, 0); wdone(); wdone(); cdone(); rdone();
        chk("zero_done", state_dbg, DONE);
        tick();
        chk("zero_comp_starts", cs_cnt, 1);
        chk("zero_layer_dones", ld_cnt, 1);

        // reset in the middle of READ_Y
        go(0, 0); wdone(); wdone(); cdone();
        chk("mid_read_y", state_dbg, READ_Y);
        ld_cnt = 0;
        areset = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_state", state_dbg, 0);
        chk("mid_rst_dma", dma_allow, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tile", tile_idx, 0);
        tick(); tick();
        areset = 1'b0;
        tick(); tick(); tick();
        chk("mid_rst_no_done", ld_cnt, 0);
        chk("mid_rst_idle", state_dbg, IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/transconv_layer_sequencer.md
TRANSCONV_LAYER_SEQUENCER -- requirements
Module: transconv_layer_sequencer

Interface
REQ-001 Parameter: TILE_W, 8, width of tile count and tile index.
REQ-002 Parameter: TIMEOUT_W, 24, width of the per-phase watchdog counter.
REQ-003 Clocking: one clock; reset is asynchronous and active-high.
REQ-004 Port: aclk  in  1  sole clock; all logic on its rising edge.
REQ-005 Port: areset  in  1  asynchronous active-high reset.
REQ-006 Port: start  in  1  one-cycle layer start request.
REQ-007 Port: abort  in  1  one-cycle abort; returns the FSM to IDLE.
REQ-008 Port: cfg_num_tiles  in  TILE_W  input tiles per layer; 0 is treated as 1.
REQ-009 Port: cfg_timeout  in  TIMEOUT_W  watchdog limit in cycles; 0 disables the watchdog.
REQ-010 Port: header_valid  in  1  parsed-header strobe from the DMA control wrapper.
REQ-011 Port: instr_code  in  8  instruction code qualified by header_valid.
REQ-012 Port: write_done  in  1  BRAM write-transfer completion pulse.
REQ-013 Port: read_done  in  1  BRAM readback completion pulse.
REQ-014 Port: comp_done  in  1  compute-engine completion pulse.
REQ-015 Port: comp_start  out  1  one-cycle compute start pulse.
REQ-016 Port: bram_owner  out  1  BRAM port owner: 0 = DMA, 1 = compute engine.
REQ-017 Port: dma_allow  out  1  DMA stream may be accepted while high.
REQ-018 Port: busy  out  1  high in any state other than IDLE.
REQ-019 Port: layer_done  out  1  one-cycle pulse when a layer completes.
REQ-020 Port: error  out  1  high in ERR; err_code is valid while high.
REQ-021 Port: err_code  out  2  1 = bad instruction, 2 = timeout, 3 = unexpected done.
REQ-022 Port: tile_idx  out  TILE_W  current tile index.
REQ-023 Port: state_dbg  out  3  encoded FSM state.

Function
REQ-024 States and encodings: IDLE=0, LOAD_W=1, LOAD_X=2, COMPUTE=3, READ_Y=4, DONE=5, ERR=6.
REQ-025 IDLE: on start, latch cfg_num_tiles and cfg_timeout, clear tile_idx, and go to LOAD_W; start is ignored in every other state.
REQ-026 LOAD_W: on write_done, go to LOAD_X.
REQ-027 LOAD_X: on write_done, go to COMPUTE and assert comp_start exactly in the first cycle in COMPUTE.
REQ-028 COMPUTE: on comp_done, go to READ_Y.
REQ-029 READ_Y: on read_done, if tile_idx == latched tiles-1 go to DONE; else increment tile_idx and go to LOAD_X.
REQ-030 DONE: assert layer_done for one cycle, then go to IDLE.
REQ-031 Header check: in LOAD_W the expected code is INSTR_WR_W (8'h01), in LOAD_X it is INSTR_WR_X (8'h02), in READ_Y it is INSTR_RD_Y (8'h03); header_valid with any other code goes to ERR with err_code=1.
REQ-032 write_done or read_done asserted in COMPUTE goes to ERR with err_code=3.
REQ-033 Watchdog: clear the counter on every state entry and increment it each cycle in LOAD_W, LOAD_X, COMPUTE and READ_Y; when it equals a nonzero latched timeout, go to ERR with err_code=2.
REQ-034 ERR: hold state, error and err_code until abort.
REQ-035 abort has the highest priority: from any state go to IDLE next cycle and clear tile_idx, err_code and the counter.
REQ-036 If the expected done pulse and a watchdog expiry occur in the same cycle, the done pulse wins.
REQ-037 bram_owner is 1 only in COMPUTE; dma_allow is 1 only in LOAD_W, LOAD_X and READ_Y.
REQ-038 All outputs are registered; a state change is visible one cycle after the triggering input.

Reset
REQ-039 While areset is high: state=IDLE; all outputs 0; latched configuration and watchdog counter 0.
REQ-040 Reset asserted mid-layer drops the transfer immediately with no completion pulse.

Structure
REQ-041 A shared package holds the state encoding, the err_code values and the INSTR_WR_W, INSTR_WR_X and INSTR_RD_Y constants.
REQ-042 One sub-module, phase_watchdog (load-clear counter with compare and disable), is instantiated once.

Verification
REQ-043 Layer run: num_tiles=2, timeout=0; drive headers 01/02/03/02/03 with matching dones -> two comp_start pulses, tile_idx goes 0 then 1, one layer_done, then IDLE.
REQ-044 Bad header: header_valid with code 8'h03 in LOAD_W -> ERR, err_code=1, dma_allow=0; then abort -> IDLE.
REQ-045 Timeout: timeout=100 and no comp_done -> ERR exactly 100 cycles after COMPUTE entry, err_code=2.
REQ-046 Race: read_done in the same cycle as watchdog expiry -> no error; next state follows REQ-029.
REQ-047 num_tiles=0 -> exactly one tile processed; areset during READ_Y -> all outputs 0, no layer_done.
